// File: rtl/ss_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter family.
package ss_pkg;
  typedef enum logic [1:0] {IDLE, PICK, SHOW} state_t;

  localparam logic [15:0] BLANK_HEX     = 16'h0000;
  localparam int          DEFAULT_DWELL = 50000000;
endpackage

// File: rtl/ss_display_arbiter_if.sv
// Requester/display bundle of ss_display_arbiter: requesters use master, the arbiter uses slave.
interface ss_display_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ-1:0]    req_clr;
  logic [16*NUM_REQ-1:0] req_data;
  logic [15:0]           hex_digits;
  logic                  disp_valid;
  logic [ID_W-1:0]       active_id;
  logic [NUM_REQ-1:0]    slot_full;

  modport master (
    output req_wr, req_clr, req_data,
    input  hex_digits, disp_valid, active_id, slot_full
  );

  modport slave (
    input  req_wr, req_clr, req_data,
    output hex_digits, disp_valid, active_id, slot_full
  );
endinterface

// File: rtl/ss_rr_pick.sv
// Combinational circular first-one finder: first set bit of req at or after start, wrapping.
module ss_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  assign dbl = {req, req};
  assign rot = dbl[start +: N];

  // Scan downward so the lowest rotated offset is the one left standing.
  always_comb begin
    sum         = '0;
    grant_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum         = (IDX_W+1)'(start) + (IDX_W+1)'(k);
        grant_valid = 1'b1;
      end
    end
    if (sum >= (IDX_W+1)'(N)) grant = IDX_W'(sum - (IDX_W+1)'(N));
    else                      grant = IDX_W'(sum);
  end
endmodule

// File: rtl/ss_display_arbiter.sv
// Round-robin sharing of one four-digit seven-segment display among NUM_REQ requesters.
// Define SS_DISPLAY_ARBITER_PRIO_EN to make slot 0 an urgent slot that preempts and holds the display.
module ss_display_arbiter
  import ss_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DWELL   = DEFAULT_DWELL,
  parameter int DWELL_W = 26
) (
  input  logic                 clk,
  input  logic                 rst_l,
  ss_display_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [15:0]        slot_data [NUM_REQ];
  logic [NUM_REQ-1:0] full;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [15:0]        hex_q, hex_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic [IDX_W-1:0]   rr_start, rr_grant, pick_id;
  logic               rr_valid, pick_valid;
  logic               urgent, preempt, hold;

  // A write wins over a clear landing on the same slot in the same cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      full <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot_data[i] <= BLANK_HEX;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_wr[i]) begin
          full[i]      <= 1'b1;
          slot_data[i] <= bus.req_data[16*i +: 16];
        end else if (bus.req_clr[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  assign rr_start = (rr_q == IDX_W'(NUM_REQ - 1)) ? '0 : rr_q + IDX_W'(1);

  ss_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req         (full),
    .start       (rr_start),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

`ifdef SS_DISPLAY_ARBITER_PRIO_EN
  assign urgent  = full[0];
  assign preempt = (id_q != '0) && (bus.req_wr[0] || full[0]);
  assign hold    = (id_q == '0);
`else
  assign urgent  = 1'b0;
  assign preempt = 1'b0;
  assign hold    = 1'b0;
`endif

  assign pick_id    = urgent ? '0 : rr_grant;
  assign pick_valid = urgent | rr_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    valid_d = valid_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|full) state_d = PICK;
      end
      PICK: begin
        if (pick_valid) begin
          id_d    = pick_id;
          hex_d   = slot_data[pick_id];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = SHOW;
          // An urgent pick leaves the rotation pointer where it was.
          if (!urgent) rr_d = pick_id;
        end else begin
          hex_d   = BLANK_HEX;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      SHOW: begin
        hex_d = slot_data[id_q];
        cnt_d = cnt_q + DWELL_W'(1);
        if (!full[id_q] || preempt)                          state_d = PICK;
        else if (cnt_q == DWELL_W'(DWELL - 1) && !hold)      state_d = PICK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hex_q   <= BLANK_HEX;
      valid_q <= 1'b0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.hex_digits = hex_q;
  assign bus.disp_valid = valid_q;
  assign bus.active_id  = id_q;
  assign bus.slot_full  = full;
endmodule

// File: doc/ss_display_arbiter.md
Name: ss_display_arbiter

Overview:
- Shares one four-digit seven-segment display between NUM_REQ independent requesters.
- Each requester posts a 16-bit hex value into its own slot. The arbiter rotates round-robin through occupied slots and shows each for DWELL clock cycles.
- It drives hex_digits of the downstream ss_driver and tags which requester is on screen.
- Sits between application logic and ss_driver in top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWELL, 50000000, clock cycles each occupied slot is displayed (≥2).
- DWELL_W, 26, dwell counter width; must satisfy 2^DWELL_W > DWELL.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  asynchronous active-low reset.
- req_wr  in  NUM_REQ  per-requester write strobe; one-cycle pulse loads req_data slice into that slot.
- req_clr  in  NUM_REQ  per-requester clear strobe; empties that slot.
- req_data  in  16*NUM_REQ  slot i value at [16*i +: 16].
- hex_digits  out  16  value for ss_driver.
- disp_valid  out  1  high when hex_digits holds a slot value; when low, ss_driver blanking is owned by top.
- active_id  out  $clog2(NUM_REQ)  index of the slot on screen.
- slot_full  out  NUM_REQ  occupancy flags.

Behaviour:
- Reset values (async, rst_l=0): all slots empty, slot_full=0, hex_digits=16'h0000, disp_valid=0, active_id=0, dwell counter=0, state=IDLE, rr pointer=0.
- Slot write, cycle N: req_wr[i]=1 loads data and sets slot_full[i] at the N+1 edge.
- Clear: req_clr[i]=1 clears slot_full[i] at the N+1 edge. Same-cycle wr and clr on one slot: wr wins (slot full, new data).
- The registered slot value becomes visible on hex_digits one cycle later. Total latency from req_wr of the active slot to hex_digits: 2 cycles.
- States:
  - IDLE: disp_valid=0. Leave when any slot_full=1 → PICK.
  - PICK (1 cycle): search from rr pointer+1 circularly, including the current slot last. The first full slot becomes active_id, and the rr pointer is set to it. Dwell counter=0 → SHOW. No full slot → IDLE, disp_valid=0.
  - SHOW: disp_valid=1; hex_digits tracks the active slot's register.
    - Counter increments every cycle.
    - At DWELL-1 → PICK. With a single occupied slot, PICK re-selects it; disp_valid stays 1 and hex_digits is unchanged through PICK.
    - Active slot cleared → PICK next cycle, ignoring remaining dwell.
- Rewriting the active slot updates hex_digits without restarting dwell.
- Writes to non-active slots never disturb the current dwell.
- Display period per slot in steady state: DWELL+1 cycles (SHOW plus PICK). hex_digits, active_id and disp_valid are registered outputs.
- Reset asserted mid-operation returns everything to reset values immediately; all slot contents are lost.

Optional Feature:
- Macro: SS_DISPLAY_ARBITER_PRIO_EN.
- Defined:
  - Slot 0 is urgent. A req_wr[0] while in SHOW on another slot forces PICK next cycle, and PICK selects slot 0 unconditionally while it is full.
  - Slot 0 then holds the display indefinitely, with no dwell rotation, until req_clr[0]. Rotation then resumes from the old rr pointer.
- Undefined: slot 0 is an ordinary round-robin member.

Decomposition:
- Shared package ss_pkg:
  - state encoding typedef (IDLE, PICK, SHOW);
  - BLANK_HEX constant 16'h0000;
  - default DWELL constant.
- One natural sub-module, ss_rr_pick: combinational circular first-one finder (request vector, start index → grant index, grant valid). It is reused by future display/LED arbiters.

Test Plan (DWELL=4, NUM_REQ=4):
1. Reset, then req_wr[2] with 16'habcd. Required:
   - slot_full=4'b0100;
   - disp_valid rises 2 cycles later, then hex_digits=abcd and active_id=2;
   - disp_valid stays 1 indefinitely.
2. Slots 0/1/3 written with 1111/2222/3333. Required: hex_digits cycles 1111→2222→3333→1111, each held exactly 5 cycles (DWELL+1).
3. While slot 1 is active, req_clr[1]. Required: next cycle PICK, then slot 3 shown. Clearing all slots → IDLE, disp_valid=0.
4. Same cycle req_wr[1]=1 with 5555 and req_clr[1]=1. Required: slot 1 full, holds 5555.
5. Active slot 3 rewritten with 7777 at dwell count 2. Required: hex_digits=7777 two cycles later; switch still occurs at the original dwell end.
6. With SS_DISPLAY_ARBITER_PRIO_EN, req_wr[0]=9999 mid-SHOW of slot 2. Required:
   - hex_digits=9999 within 2 cycles and held beyond 20 cycles;
   - after req_clr[0], slot 3 is displayed next.
